mdu_seq: RTL

- Iterative multiply/divide unit with its own sequencing FSM for the RV64IM execute stage.
- Issued when the decoder asserts mdu_en: opcode OP/OP_32 with funct7 = 0000001.
- Takes funct3 and inst_32 from decode, runs one shift-add or restoring-divide step per cycle, and returns a result selected by the RD_SRC_MDU writeback path.
- Uses a valid/ready handshake on both sides so the pipeline stalls while it is busy.

---
 rtl/mdu_seq_pkg.sv | 33 +++
 rtl/mdu_div_step.sv | 28 ++
 rtl/mdu_seq.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/mdu_seq_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   - funct3 operation codes of the M extension (MDU_MUL .. MDU_REMU)
//   - FSM state encoding of mdu_seq
//   - operand signedness decode helpers
package mdu_seq_pkg;

  localparam logic [2:0] MDU_MUL    = 3'b000;
  localparam logic [2:0] MDU_MULH   = 3'b001;
  localparam logic [2:0] MDU_MULHSU = 3'b010;
  localparam logic [2:0] MDU_MULHU  = 3'b011;
  localparam logic [2:0] MDU_DIV    = 3'b100;
  localparam logic [2:0] MDU_DIVU   = 3'b101;
  localparam logic [2:0] MDU_REM    = 3'b110;
  localparam logic [2:0] MDU_REMU   = 3'b111;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_CALC = 2'd1,
    MDU_FIX  = 2'd2,
    MDU_DONE = 2'd3
  } mdu_state_e;

  // rs1 is a signed operand for MULH, MULHSU, DIV, REM
  function automatic logic src1_signed(input logic [2:0] f3);
    return f3 inside {MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM};
  endfunction

  // rs2 is a signed operand for MULH, DIV, REM (MULHSU takes it unsigned)
  function automatic logic src2_signed(input logic [2:0] f3);
    return f3 inside {MDU_MULH, MDU_DIV, MDU_REM};
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division iteration (purely combinational).
// Ports:
//   rem_i  : current partial remainder (always < div_i)
//   bit_i  : next dividend bit shifted in at the bottom
//   div_i  : divisor magnitude
//   rem_o  : partial remainder after the trial subtract
//   qbit_o : quotient bit produced by this step
module mdu_div_step #(
  parameter int DATA_W = 64
) (
  input  logic [DATA_W-1:0] rem_i,
  input  logic              bit_i,
  input  logic [DATA_W-1:0] div_i,
  output logic [DATA_W-1:0] rem_o,
  output logic              qbit_o
);

  // The shifted remainder needs one extra bit; both outcomes fit back
  // into DATA_W bits because the result is always below the divisor.
  logic [DATA_W:0] shifted;
  logic [DATA_W:0] trial;

  assign shifted = {rem_i, bit_i};
  assign trial   = shifted - {1'b0, div_i};
  assign qbit_o  = (shifted >= {1'b0, div_i});
  assign rem_o   = qbit_o ? trial[DATA_W-1:0] : shifted[DATA_W-1:0];

endmodule

// File: rtl/mdu_seq.sv
// Iterative multiply/divide unit for the RV64IM execute stage.
// Shift-add multiply and restoring divide on operand magnitudes, one bit
// per cycle, followed by a single sign fix-up cycle.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : operation offer / unit idle and able to accept
//   funct3, inst_32      : M-extension operation and word-op flag
//   src1, src2           : rs1 / rs2 values, sampled only at accept
//   flush                : kill any in-flight operation
//   out_valid / out_ready: result handshake with writeback
//   result               : rd value, held while out_valid
//   busy                 : unit not idle
module mdu_seq
  import mdu_seq_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic            inst_32,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int CW = $clog2(XLEN);
  localparam int PW = 2 * XLEN;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    logic signed [31:0] s;
    s = v;
    return XLEN'(s);
  endfunction

  function automatic logic [XLEN-1:0] zext32(input logic [31:0] v);
    return XLEN'(v);
  endfunction

  mdu_state_e      state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [XLEN-1:0] result_q, result_d;

  logic [2:0]      op_q;
  logic            w32_q;
  logic            negq_q;   // negate product / quotient
  logic            negr_q;   // negate remainder (dividend was negative)
  logic [XLEN-1:0] a_q;      // multiplicand / divisor magnitude
  logic [XLEN-1:0] b_q;      // multiplier / dividend magnitude
  logic [PW-1:0]   prod_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] quo_q;

  // Accept-time operand conditioning
  logic            w32_in, sgn1_in, sgn2_in, neg1_in, neg2_in;
  logic [XLEN-1:0] op1_n, op2_n, mag1, mag2, most_neg, short_res;
  logic            div0_in, ovf_in, short_in, accept;

  // Word ops only exist on RV64
  assign w32_in  = (XLEN == 64) && inst_32;
  assign sgn1_in = src1_signed(funct3);
  assign sgn2_in = src2_signed(funct3);

  always_comb begin
    op1_n = src1;
    op2_n = src2;
    if (w32_in) begin
      op1_n = sgn1_in ? sext32(src1[31:0]) : zext32(src1[31:0]);
      op2_n = sgn2_in ? sext32(src2[31:0]) : zext32(src2[31:0]);
    end
    neg1_in  = sgn1_in & op1_n[XLEN-1];
    neg2_in  = sgn2_in & op2_n[XLEN-1];
    mag1     = neg1_in ? -op1_n : op1_n;
    mag2     = neg2_in ? -op2_n : op2_n;
    most_neg = w32_in ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
    div0_in  = (op2_n == '0);
    ovf_in   = sgn1_in && (op1_n == most_neg) && (&op2_n);
    short_in = funct3[2] && (div0_in || ovf_in);
    // funct3[1] distinguishes REM/REMU from DIV/DIVU
    if (div0_in) short_res = funct3[1] ? op1_n : '1;
    else         short_res = funct3[1] ? '0 : op1_n;
    if (w32_in) short_res = sext32(short_res[31:0]);
  end

  assign accept = (state_q == MDU_IDLE) && in_valid && !flush;

  logic [XLEN-1:0] rem_nx;
  logic            qbit;

  mdu_div_step #(.DATA_W(XLEN)) u_div_step (
    .rem_i  (rem_q),
    .bit_i  (b_q[count_q]),
    .div_i  (a_q),
    .rem_o  (rem_nx),
    .qbit_o (qbit)
  );

  // Sign fix-up and result selection
  logic [PW-1:0]   prod_s;
  logic [XLEN-1:0] quo_s, rem_s, fix_raw, fix_res;

  always_comb begin
    prod_s = negq_q ? -prod_q : prod_q;
    quo_s  = negq_q ? -quo_q : quo_q;
    rem_s  = negr_q ? -rem_q : rem_q;
    case (op_q)
      MDU_MUL:                        fix_raw = prod_s[XLEN-1:0];
      MDU_MULH, MDU_MULHSU, MDU_MULHU: fix_raw = prod_s[PW-1:XLEN];
      MDU_DIV, MDU_DIVU:               fix_raw = quo_s;
      default:                         fix_raw = rem_s;
    endcase
    fix_res = w32_q ? sext32(fix_raw[31:0]) : fix_raw;
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    result_d = result_q;
    if (flush) begin
      state_d = MDU_IDLE;
    end else begin
      case (state_q)
        MDU_IDLE: if (in_valid) begin
          if (short_in) begin
            state_d  = MDU_DONE;
            result_d = short_res;
          end else begin
            state_d = MDU_CALC;
            count_d = w32_in ? CW'(31) : CW'(XLEN - 1);
          end
        end
        MDU_CALC: if (count_q == '0) state_d = MDU_FIX;
                  else               count_d = count_q - 1'b1;
        MDU_FIX: begin
          result_d = fix_res;
          state_d  = MDU_DONE;
        end
        default: if (out_ready) state_d = MDU_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= MDU_IDLE;
      count_q  <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      result_q <= result_d;
    end
  end

  // Datapath: loaded at accept, stepped MSB-first while in CALC
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q   <= funct3;
      w32_q  <= w32_in;
      negq_q <= neg1_in ^ neg2_in;
      negr_q <= neg1_in;
      a_q    <= mag2;
      b_q    <= mag1;
      prod_q <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
    end else if (state_q == MDU_CALC) begin
      prod_q <= {prod_q[PW-2:0], 1'b0} + (b_q[count_q] ? PW'(a_q) : '0);
      rem_q  <= rem_nx;
      quo_q  <= {quo_q[XLEN-2:0], qbit};
    end
  end

  assign in_ready  = (state_q == MDU_IDLE);
  assign busy      = (state_q != MDU_IDLE);
  assign out_valid = (state_q == MDU_DONE);
  assign result    = result_q;

endmodule
